// File: rtl/sr_cmd_pkg.sv
// sr_cmd_pkg: shared FSM state encoding and default parameters for sr_cmd_gen
package sr_cmd_pkg;
  typedef enum logic [1:0] {IDLE, SET_P, CLR_P, HOLD} state_t;
  localparam int DB_CYCLES_DEF = 4;
  localparam int PULSE_LEN_DEF = 1;
  localparam int HOLDOFF_DEF = 2;
endpackage

// File: rtl/debounce.sv
// debounce: output follows input only after DB_CYCLES consecutive differing samples
module debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);
  logic [7:0] cnt;
  // count consecutive samples that disagree with the filtered value; any agreement restarts the count
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      dout <= 1'b0;
    end else if (din == dout) begin
      cnt <= '0;
    end else if (cnt == 8'(DB_CYCLES - 1)) begin
      cnt <= '0;
      dout <= din;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end
endmodule

// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: debounced set/clear requests to mutually exclusive s/r pulses with holdoff
module sr_cmd_gen
  import sr_cmd_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int PULSE_LEN = PULSE_LEN_DEF,
  parameter int HOLDOFF = HOLDOFF_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic set_req,
  input  logic clr_req,
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict
);
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic set_f, clr_f, set_q, clr_q, set_ev, clr_ev, conflict_n;
  debounce #(.DB_CYCLES(DB_CYCLES)) u_set (.clk(clk), .reset(reset), .din(set_req), .dout(set_f));
  debounce #(.DB_CYCLES(DB_CYCLES)) u_clr (.clk(clk), .reset(reset), .din(clr_req), .dout(clr_f));
  assign set_ev = set_f & ~set_q;
  assign clr_ev = clr_f & ~clr_q;
  assign busy = state != IDLE;
  // next state: events only matter in IDLE, pulse and holdoff phases share one counter
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    conflict_n = conflict;
    case (state)
      IDLE: begin
        if (set_ev && clr_ev) conflict_n = 1'b1;
        else if (set_ev) state_n = SET_P;
        else if (clr_ev) state_n = CLR_P;
      end
      SET_P, CLR_P: begin
        state_n = cnt == 4'(PULSE_LEN - 1) ? HOLD : state;
        cnt_n = cnt == 4'(PULSE_LEN - 1) ? 4'd0 : cnt + 4'd1;
      end
      HOLD: begin
        state_n = cnt == 4'(HOLDOFF - 1) ? IDLE : HOLD;
        cnt_n = cnt == 4'(HOLDOFF - 1) ? 4'd0 : cnt + 4'd1;
      end
    endcase
  end
  // state, edge-detect history and registered s/r decoded from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      conflict <= 1'b0;
      set_q <= 1'b0;
      clr_q <= 1'b0;
      s <= 1'b0;
      r <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      conflict <= conflict_n;
      set_q <= set_f;
      clr_q <= clr_f;
      s <= state_n == SET_P;
      r <= state_n == CLR_P;
    end
  end
endmodule

// File: tb/tb_sr_cmd_gen.sv
// tb_sr_cmd_gen: directed and randomized checks of sr_cmd_gen against a behavioural model
module tb_sr_cmd_gen;
  localparam int DB = 4;
  localparam int PL = 2;
  localparam int HO = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic set_req = 1'b0;
  logic clr_req = 1'b0;
  logic s, r, busy, conflict;
  int checks = 0;
  int errors = 0;
  int m_filt[2];
  int m_prev[2];
  int m_run[2];
  int m_rem = 0;
  int m_kind = 0;
  int m_conf = 0;

  sr_cmd_gen #(.DB_CYCLES(DB), .PULSE_LEN(PL), .HOLDOFF(HO)) dut (
    .clk(clk), .reset(reset), .set_req(set_req), .clr_req(clr_req),
    .s(s), .r(r), .busy(busy), .conflict(conflict)
  );

  always #5 clk = ~clk;

  // model: remaining busy cycles after a command, pulse while more than HOLDOFF remain
  task automatic tick();
    logic [1:0] raw;
    bit ev0, ev1;
    @(posedge clk);
    raw = {clr_req, set_req};
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_filt[i] = 0;
        m_prev[i] = 0;
        m_run[i] = 0;
      end
      m_rem = 0;
      m_kind = 0;
      m_conf = 0;
    end else begin
      ev0 = m_filt[0] == 1 && m_prev[0] == 0;
      ev1 = m_filt[1] == 1 && m_prev[1] == 0;
      if (m_rem > 0) m_rem--;
      else if (ev0 && ev1) m_conf = 1;
      else if (ev0 || ev1) begin
        m_rem = PL + HO;
        m_kind = ev0 ? 1 : 2;
      end
      for (int i = 0; i < 2; i++) begin
        m_prev[i] = m_filt[i];
        if (int'(raw[i]) != m_filt[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_filt[i] = int'(raw[i]);
            m_run[i] = 0;
          end
        end else m_run[i] = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_req = 1'b0;
    clr_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_req = 1'b1;
    clr_req = 1'b1;
    tick();
    checks++;
    if ({s, r, busy, conflict} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000", {s, r, busy, conflict});
    end
    do_reset();
  endtask

  task automatic test_single_set();
    do_reset();
    set_req = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      checks += 3;
      if (s !== 1'(e == 5 || e == 6)) begin
        errors++;
        $display("FAIL single_set_s edge %0d: got %b expected %b", e, s, e == 5 || e == 6);
      end
      if (busy !== 1'(e >= 5 && e <= 8)) begin
        errors++;
        $display("FAIL single_set_busy edge %0d: got %b expected %b", e, busy, e >= 5 && e <= 8);
      end
      if (r !== 1'b0) begin
        errors++;
        $display("FAIL single_set_r edge %0d: got %b expected 0", e, r);
      end
    end
    set_req = 1'b0;
  endtask

  task automatic test_bounce();
    bit pat[7] = '{1, 1, 1, 0, 1, 1, 0};
    do_reset();
    for (int e = 0; e < 16; e++) begin
      set_req = e < 7 ? pat[e] : 1'b0;
      tick();
      checks++;
      if ({s, r, busy} !== 3'b000) begin
        errors++;
        $display("FAIL bounce edge %0d: got s,r,busy=%b expected 000", e + 1, {s, r, busy});
      end
    end
  endtask

  task automatic test_conflict();
    do_reset();
    set_req = 1'b1;
    clr_req = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks += 2;
      if (conflict !== 1'(e >= 5)) begin
        errors++;
        $display("FAIL conflict_flag edge %0d: got %b expected %b", e, conflict, e >= 5);
      end
      if ({s, r, busy} !== 3'b000) begin
        errors++;
        $display("FAIL conflict_no_pulse edge %0d: got %b expected 000", e, {s, r, busy});
      end
    end
    set_req = 1'b0;
    clr_req = 1'b0;
    repeat (20) tick();
    checks++;
    if (conflict !== 1'b1) begin
      errors++;
      $display("FAIL conflict_sticky: got %b expected 1", conflict);
    end
  endtask

  task automatic test_drop_while_busy();
    do_reset();
    set_req = 1'b1;
    for (int e = 1; e <= 24; e++) begin
      if (e == 4) clr_req = 1'b1;
      tick();
      checks += 2;
      if (r !== 1'b0) begin
        errors++;
        $display("FAIL drop_r edge %0d: got %b expected 0", e, r);
      end
      if (s !== 1'(e == 5 || e == 6)) begin
        errors++;
        $display("FAIL drop_s edge %0d: got %b expected %b", e, s, e == 5 || e == 6);
      end
    end
    set_req = 1'b0;
    clr_req = 1'b0;
  endtask

  task automatic test_reset_mid_pulse();
    int s_cnt = 0;
    int r_cnt = 0;
    do_reset();
    set_req = 1'b1;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({s, r, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid: got s,r,busy=%b expected 000", {s, r, busy});
    end
    reset = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      tick();
      s_cnt += int'(s);
      r_cnt += int'(r);
      if (e == 5) begin
        checks++;
        if (s !== 1'b1) begin
          errors++;
          $display("FAIL rearm_s_edge5: got %b expected 1", s);
        end
      end
    end
    checks += 2;
    if (s_cnt != PL) begin
      errors++;
      $display("FAIL rearm_pulse_len: got %0d expected %0d", s_cnt, PL);
    end
    if (r_cnt != 0) begin
      errors++;
      $display("FAIL rearm_r: got %0d expected 0", r_cnt);
    end
    set_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_req = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      if (e == 19) clr_req = 1'b1;
      tick();
      checks += 2;
      if (r !== 1'(e == 23 || e == 24)) begin
        errors++;
        $display("FAIL second_r edge %0d: got %b expected %b", e, r, e == 23 || e == 24);
      end
      if (s !== 1'(e == 5 || e == 6)) begin
        errors++;
        $display("FAIL second_s edge %0d: got %b expected %b", e, s, e == 5 || e == 6);
      end
    end
    set_req = 1'b0;
    clr_req = 1'b0;
  endtask

  task automatic test_random();
    logic es, er;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 5) == 0) set_req = ~set_req;
      if ($urandom_range(0, 5) == 0) clr_req = ~clr_req;
      reset = $urandom_range(0, 199) == 0;
      tick();
      es = m_rem > HO && m_kind == 1;
      er = m_rem > HO && m_kind == 2;
      checks++;
      if ({s, r, busy, conflict} !== {es, er, 1'(m_rem > 0), 1'(m_conf != 0)}) begin
        errors++;
        $display("FAIL random cycle %0d: got s,r,busy,conflict=%b expected %b", n, {s, r, busy, conflict},
                 {es, er, 1'(m_rem > 0), 1'(m_conf != 0)});
      end
      if (s && r) begin
        checks++;
        errors++;
        $display("FAIL random_exclusive cycle %0d: got s=r=1 expected never both", n);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_set();
    test_bounce();
    test_conflict();
    test_drop_while_busy();
    test_reset_mid_pulse();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sr_cmd_gen.md
SR_CMD_GEN -- requirements
Module: sr_cmd_gen

Interface
REQ-001 Parameter DB_CYCLES, default 4, number of consecutive stable samples (1..255) before a debounced input changes.
REQ-002 Parameter PULSE_LEN, default 1, number of cycles (1..15) s or r is held high per command.
REQ-003 Parameter HOLDOFF, default 2, number of idle cycles (1..15) after each pulse before a new command is accepted.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 set_req  input  1  raw set request, synchronous to clk, may bounce.
REQ-007 clr_req  input  1  raw clear request, synchronous to clk, may bounce.
REQ-008 s  output  1  registered set command to the downstream SR flip-flop.
REQ-009 r  output  1  registered reset command to the downstream SR flip-flop.
REQ-010 busy  output  1  high while a command pulse or holdoff is in progress.
REQ-011 conflict  output  1  sticky flag: simultaneous set and clear events were seen.

Function
REQ-012 Each of set_req and clr_req SHALL pass through an independent debouncer.
REQ-013 A debouncer's filtered output SHALL change only after the raw input differs from the filtered value for DB_CYCLES consecutive edges; the counter clears whenever raw equals filtered.
REQ-014 A rising edge of a filtered input SHALL be a set event or a clear event; falling edges generate nothing.
REQ-015 The FSM SHALL have states IDLE, SET_P, CLR_P and HOLD, and SHALL reset to IDLE.
REQ-016 In IDLE, a lone set event SHALL move to SET_P and a lone clear event SHALL move to CLR_P on the next edge.
REQ-017 SET_P SHALL drive s=1, r=0 for exactly PULSE_LEN cycles, then move to HOLD; CLR_P SHALL do the same with r=1, s=0.
REQ-018 HOLD SHALL drive s=r=0 for exactly HOLDOFF cycles, then return to IDLE.
REQ-019 Events arriving in SET_P, CLR_P or HOLD SHALL be discarded: no queuing and no conflict flag.
REQ-020 Set and clear events in the same IDLE cycle SHALL issue no pulse, keep the FSM in IDLE, and set conflict on that edge.
REQ-021 s and r SHALL never be 1 in the same cycle, so the downstream 2'b11 input never occurs.
REQ-022 Latency SHALL be: raw input stable from before edge 1 gives filtered high after edge DB_CYCLES, and s or r high after edge DB_CYCLES+1.
REQ-023 busy SHALL equal (state != IDLE).
REQ-024 conflict SHALL clear only on reset.
REQ-025 The pulse-length and holdoff counter SHALL be 4 bits wide, and the debounce counters SHALL be 8 bits wide, with no wrap-around reachable for legal parameter values.

Reset
REQ-026 With reset=1 at an edge, reset SHALL take priority over all other inputs and set state=IDLE, s=0, r=0, busy=0, conflict=0, all counters=0 and filtered values=0.
REQ-027 A reset asserted mid-pulse or mid-holdoff SHALL terminate it at that edge, and the interrupted command SHALL not resume.
REQ-028 After reset deasserts, a request input already held high SHALL be debounced afresh and SHALL produce one pulse.

Structure
REQ-029 The FSM state encodings and the default parameter values SHALL reside in the shared package sr_cmd_pkg.
REQ-030 The debouncer SHALL be a sub-module named debounce, with ports clk, reset, din and dout and parameter DB_CYCLES, instantiated twice.

Verification (DB_CYCLES=4, PULSE_LEN=2, HOLDOFF=2)
REQ-031 set_req=1 from before edge 1, held 12 cycles -> s=1 after edges 5-6 only; busy=1 after edges 5-8; r=0 throughout.
REQ-032 set_req with bouncing pattern 1,1,1,0,1,1,0 -> s, r and busy stay 0.
REQ-033 set_req and clr_req rising together, held 8 cycles -> no s/r pulse; conflict=1 after edge 5 and still 1 twenty cycles later.
REQ-034 Set command issued, then clr_req rises at edge 3 and is held -> clear event lands during busy and is dropped; no r pulse follows.
REQ-035 reset=1 at the edge where s would be in its 2nd cycle -> s=0, busy=0 after that edge; FSM in IDLE.
REQ-036 Set pulse completes, then clr_req rises 10 cycles later -> r=1 for 2 cycles, at DB_CYCLES+1 edges after the clr_req rise; s=0 during it.
